regfile_writeback_unit: RTL and testbench

Write-side front end for the 32x32 register file. Collects writeback requests from the ALU path and the load path, orders them in a small FIFO, and drives the register file write port (RegWrite / Rd / Write_data) with at most one write per cycle. Also reports which source registers have writes still queued and forwards the youngest queued value, so decode can stall or bypass.

---
 rtl/regfile_writeback_unit.sv | 148 ++++++++++++++
 tb/tb_regfile_writeback_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
// Write-side front end for the 32x32 register file. ALU and load writebacks
// are merged into a small circular queue and drained to the single register
// file write port, one entry per cycle. Decode can query the queue for
// pending writes to its source registers and receives the youngest queued
// value for bypassing.
//
// Writes to x0 are accepted but discarded, so every valid entry holds a real
// architectural write. Valid entries are always the contiguous range from
// head for count entries.

module regfile_writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     load_valid,
    input  logic [4:0]               load_rd,
    input  logic [XLEN-1:0]          load_data,
    output logic                     load_ready,

    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_ready,

    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_wdata,

    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     rs1_pending,
    output logic                     rs2_pending,
    output logic [XLEN-1:0]          rs1_fwd,
    output logic [XLEN-1:0]          rs2_fwd,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_rd   [DEPTH];
    logic [XLEN-1:0]  ent_data [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    alu_slot;

    logic [CW-1:0]    free;
    logic [CW-1:0]    push_cnt;
    logic             load_push;
    logic             alu_push;
    logic             pop;

    // Space is judged on the registered count only; a same-cycle pop frees
    // its slot for the following cycle. Load wins the last free slot.
    assign free       = DEPTH_C - count;
    assign load_ready = (free != '0);
    assign alu_ready  = (free >= CW'(2)) || ((free == CW'(1)) && !load_valid);

    // x0 requests handshake normally but never occupy a slot.
    assign load_push = load_valid && load_ready && (load_rd != 5'd0);
    assign alu_push  = alu_valid  && alu_ready  && (alu_rd  != 5'd0);
    assign pop       = (count != '0);

    // The ALU entry lands behind the load entry when both are written.
    assign alu_slot  = load_push ? (tail + PW'(1)) : tail;
    assign push_cnt  = CW'(load_push) + CW'(alu_push);

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // Queue pointers, occupancy and per-entry valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (load_push) begin
                ent_valid[tail] <= 1'b1;
            end
            if (alu_push) begin
                ent_valid[alu_slot] <= 1'b1;
            end
            tail  <= tail + PW'(push_cnt);
            count <= count + push_cnt - CW'(pop);
        end
    end

    // Entry payload; contents are only meaningful while the valid flag is set.
    always_ff @(posedge clk) begin
        if (load_push) begin
            ent_rd[tail]   <= load_rd;
            ent_data[tail] <= load_data;
        end
        if (alu_push) begin
            ent_rd[alu_slot]   <= alu_rd;
            ent_data[alu_slot] <= alu_data;
        end
    end

    // Head entry drives the register file port whenever the queue is occupied.
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (pop) begin
            rf_we    = 1'b1;
            rf_rd    = ent_rd[head];
            rf_wdata = ent_data[head];
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        rs1_fwd     = '0;
        rs2_fwd     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[head + PW'(i)]) begin
                if ((rs1 != 5'd0) && (ent_rd[head + PW'(i)] == rs1)) begin
                    rs1_pending = 1'b1;
                    rs1_fwd     = ent_data[head + PW'(i)];
                end
                if ((rs2 != 5'd0) && (ent_rd[head + PW'(i)] == rs2)) begin
                    rs2_pending = 1'b1;
                    rs2_fwd     = ent_data[head + PW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Testbench for regfile_writeback_unit: a DEPTH=4 instance (primary) and a
// DEPTH=2 instance share the same inputs; each is compared every cycle
// against its own queue-based reference model.

module tb_regfile_writeback_unit;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_valid, alu_valid;
    logic [4:0]      load_rd, alu_rd, rs1, rs2;
    logic [XLEN-1:0] load_data, alu_data;

    logic            a_lr, a_ar, a_we, a_p1, a_p2, a_empty, a_full;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_wd, a_f1, a_f2;
    logic [2:0]      a_cnt;

    logic            b_lr, b_ar, b_we, b_p1, b_p2, b_empty, b_full;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_wd, b_f1, b_f2;
    logic [1:0]      b_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t mq [2][$];

    always #5 clk = ~clk;

    regfile_writeback_unit #(.XLEN(XLEN), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(a_lr),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(a_ar),
        .rf_we(a_we), .rf_rd(a_rd), .rf_wdata(a_wd),
        .rs1(rs1), .rs2(rs2), .rs1_pending(a_p1), .rs2_pending(a_p2),
        .rs1_fwd(a_f1), .rs2_fwd(a_f2),
        .count(a_cnt), .empty(a_empty), .full(a_full)
    );

    regfile_writeback_unit #(.XLEN(XLEN), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(b_lr),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(b_ar),
        .rf_we(b_we), .rf_rd(b_rd), .rf_wdata(b_wd),
        .rs1(rs1), .rs2(rs2), .rs1_pending(b_p1), .rs2_pending(b_p2),
        .rs1_fwd(b_f1), .rs2_fwd(b_f2),
        .count(b_cnt), .empty(b_empty), .full(b_full)
    );

    function automatic int depth_of(input int m);
        return (m == 0) ? 4 : 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Youngest queued write to rs, searched from the tail end of the model queue.
    task automatic lookup(input int m, input logic [4:0] rs, output logic p, output logic [31:0] f);
        p = 1'b0;
        f = '0;
        if (rs != 5'd0) begin
            for (int i = mq[m].size() - 1; i >= 0; i--) begin
                if (mq[m][i].rd == rs) begin
                    p = 1'b1;
                    f = mq[m][i].data;
                    break;
                end
            end
        end
    endtask

    function automatic bit model_lacc(input int m);
        int fr = depth_of(m) - mq[m].size();
        return load_valid && (fr >= 1);
    endfunction

    function automatic bit model_aacc(input int m);
        int fr = depth_of(m) - mq[m].size();
        return alu_valid && ((fr >= 2) || ((fr == 1) && !load_valid));
    endfunction

    task automatic check_dut(input int m, input string pfx,
                             input logic lr, input logic ar, input logic we,
                             input logic [4:0] rd, input logic [31:0] wd,
                             input logic p1, input logic [31:0] f1,
                             input logic p2, input logic [31:0] f2,
                             input int cnt, input logic emp, input logic ful);
        int          n = mq[m].size();
        logic        ep1, ep2;
        logic [31:0] ef1, ef2;
        lookup(m, rs1, ep1, ef1);
        lookup(m, rs2, ep2, ef2);
        chk({pfx, "_load_ready"}, lr, (depth_of(m) - n) >= 1);
        chk({pfx, "_alu_ready"}, ar, model_aacc(m) || !alu_valid && (((depth_of(m) - n) >= 2) || ((depth_of(m) - n) == 1 && !load_valid)));
        chk({pfx, "_rf_we"}, we, n > 0);
        chk({pfx, "_rf_rd"}, rd, (n > 0) ? mq[m][0].rd : 5'd0);
        chk({pfx, "_rf_wdata"}, wd, (n > 0) ? mq[m][0].data : 32'd0);
        chk({pfx, "_rs1_pending"}, p1, ep1);
        chk({pfx, "_rs1_fwd"}, f1, ef1);
        chk({pfx, "_rs2_pending"}, p2, ep2);
        chk({pfx, "_rs2_fwd"}, f2, ef2);
        chk({pfx, "_count"}, cnt, n);
        chk({pfx, "_empty"}, emp, n == 0);
        chk({pfx, "_full"}, ful, n == depth_of(m));
    endtask

    // Reference behaviour at a rising edge: drop all on reset, else pop head
    // then append accepted non-x0 requests, load first.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mq[m].delete();
            end else begin
                bit la = model_lacc(m);
                bit aa = model_aacc(m);
                if (mq[m].size() > 0) void'(mq[m].pop_front());
                if (la && load_rd != 5'd0) mq[m].push_back({load_rd, load_data});
                if (aa && alu_rd != 5'd0) mq[m].push_back({alu_rd, alu_data});
            end
        end
    endtask

    // One clock: check both DUTs mid-cycle, advance models at the edge.
    // Reports whether the primary (DEPTH=4) instance accepted each request.
    task automatic step(output bit lacc, output bit aacc);
        @(negedge clk);
        check_dut(0, "d4", a_lr, a_ar, a_we, a_rd, a_wd, a_p1, a_f1, a_p2, a_f2, int'(a_cnt), a_empty, a_full);
        check_dut(1, "d2", b_lr, b_ar, b_we, b_rd, b_wd, b_p1, b_f1, b_p2, b_f2, int'(b_cnt), b_empty, b_full);
        lacc = !rst && model_lacc(0);
        aacc = !rst && model_aacc(0);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        bit       la, aa;
        int       next_rd;

        rst = 1'b1;
        load_valid = 1'b0; load_rd = '0; load_data = '0;
        alu_valid  = 1'b0; alu_rd  = '0; alu_data  = '0;
        rs1 = 5'd5; rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle.
        step(la, aa);
        rst = 1'b0;
        step(la, aa);
        chk("idle_empty", a_empty, 1'b1);
        chk("idle_rs1_pending", a_p1, 1'b0);

        // Single ALU write x3 = 0xC.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_000C; rs1 = 5'd3;
        step(la, aa);
        alu_valid = 1'b0;
        chk("x3_we", a_we, 1'b1);
        chk("x3_rd", a_rd, 5'd3);
        chk("x3_wdata", a_wd, 32'hC);
        chk("x3_pending", a_p1, 1'b1);
        step(la, aa);
        chk("x3_done_we", a_we, 1'b0);
        chk("x3_done_empty", a_empty, 1'b1);

        // Simultaneous load x4 = 0x14 and ALU x4 = 0x99.
        load_valid = 1'b1; load_rd = 5'd4; load_data = 32'h14;
        alu_valid  = 1'b1; alu_rd  = 5'd4; alu_data  = 32'h99;
        rs1 = 5'd4;
        step(la, aa);
        load_valid = 1'b0; alu_valid = 1'b0;
        chk("x4_pending", a_p1, 1'b1);
        chk("x4_fwd", a_f1, 32'h99);
        chk("x4_first_rd", a_rd, 5'd4);
        chk("x4_first_wdata", a_wd, 32'h14);
        step(la, aa);
        chk("x4_second_wdata", a_wd, 32'h99);
        chk("x4_second_fwd", a_f1, 32'h99);
        step(la, aa);
        chk("x4_done_empty", a_empty, 1'b1);
        chk("x4_done_pending", a_p1, 1'b0);

        // x0 write is handshaken but discarded.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF; rs1 = 5'd0;
        #1;
        chk("x0_alu_ready", a_ar, 1'b1);
        step(la, aa);
        alu_valid = 1'b0;
        chk("x0_count", a_cnt, 3'd0);
        chk("x0_we", a_we, 1'b0);
        chk("x0_pending", a_p1, 1'b0);

        // Fill with 2-per-cycle bursts; inputs held until the primary accepts.
        next_rd = 5;
        load_valid = 1'b1; load_rd = 5'(next_rd); load_data = 32'h100 + next_rd; next_rd++;
        alu_valid  = 1'b1; alu_rd  = 5'(next_rd); alu_data  = 32'h100 + next_rd; next_rd++;
        rs1 = 5'd6; rs2 = 5'd8;
        step(la, aa);
        chk("d2_full", b_full, 1'b1);
        chk("d2_full_load_ready", b_lr, 1'b0);
        chk("d2_full_alu_ready", b_ar, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (la) begin load_rd = 5'(next_rd); load_data = 32'h100 + next_rd; next_rd++; end
            if (aa) begin alu_rd  = 5'(next_rd); alu_data  = 32'h100 + next_rd; next_rd++; end
            if (c == 1) begin
                #1;
                chk("free1_load_ready", a_lr, 1'b1);
                chk("free1_alu_ready", a_ar, 1'b0);
            end
            step(la, aa);
        end
        chk("fill_count", a_cnt, 3'd3);

        // Reset with three entries queued drops them.
        load_valid = 1'b0; alu_valid = 1'b0;
        rs1 = mq[0][1].rd; rs2 = mq[0][2].rd;
        rst = 1'b1;
        step(la, aa);
        rst = 1'b0;
        chk("rst_we", a_we, 1'b0);
        chk("rst_count", a_cnt, 3'd0);
        chk("rst_rs1_pending", a_p1, 1'b0);
        chk("rst_rs2_pending", a_p2, 1'b0);
        repeat (3) step(la, aa);

        // Randomised traffic with valid/ready holding on the primary.
        la = 1'b0; aa = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!load_valid || la) begin
                load_valid = ($urandom_range(0, 2) != 0);
                load_rd    = 5'($urandom_range(0, 7));
                load_data  = $urandom;
            end
            if (!alu_valid || aa) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            step(la, aa);
        end
        rst = 1'b0;
        load_valid = 1'b0; alu_valid = 1'b0;
        repeat (6) step(la, aa);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
